// File: rtl/pll_cen_pkg.sv
// Shared types and helpers for the lock-gated clock-enable generator.
// Holds the controller state encoding and the increment saturation rule.
package pll_cen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLDOFF,
    RUN
  } state_t;

  localparam int MAX_CH = 8;

  // Increments above one full turn of the accumulator behave as "every cycle".
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int acc_w);
    logic [31:0] limit;
    limit = 32'd1 << acc_w;
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pll_cen_acc.sv
// Single-channel phase accumulator; the carry out of the accumulator is the enable.
// Holding or clearing the accumulator keeps every channel phase-aligned at RUN entry.
module pll_cen_acc
  import pll_cen_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [ACC_W:0]   inc,
  output logic             cen
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + inc;
  end

  always_ff @(posedge refclk) begin
    if (rst || clr || !run) begin
      acc <= '0;
      cen <= 1'b0;
    end else begin
      acc <= sum[ACC_W-1:0];
      cen <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/pll_cen_gen.sv
// Lock-gated generator of NUM_CH programmable fractional clock enables.
// Enables run only after the synchronised lock has been stable for HOLD_CYCLES cycles.
module pll_cen_gen
  import pll_cen_pkg::*;
#(
  parameter int                              NUM_CH      = 2,
  parameter int                              ACC_W       = 16,
  parameter int                              HOLD_CYCLES = 1024,
  parameter logic [NUM_CH*(ACC_W+1)-1:0]     DEFAULT_INC = {17'h08000, 17'h04000}
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          pll_locked,
  input  logic                          inc_load,
  input  logic [NUM_CH*(ACC_W+1)-1:0]   inc_in,
  input  logic                          unlock_clr,
  output logic [NUM_CH-1:0]             cen,
  output logic                          ready,
  output logic                          unlock_seen
);

  localparam int IW    = ACC_W + 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // The WAIT_LOCK cycle that sees lk=1 counts as the first locked cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);

  state_t           state, state_next;
  logic             sync1, lk;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [IW-1:0]    inc_reg [NUM_CH];
  logic             acc_run;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_comb begin
    state_next    = state;
    hold_cnt_next = '0;
    unique case (state)
      WAIT_LOCK: if (lk) state_next = HOLDOFF;
      HOLDOFF: begin
        if (!lk) begin
          state_next = WAIT_LOCK;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state_next = RUN;
        end
      end
      RUN:     if (!lk) state_next = WAIT_LOCK;
      default: state_next = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      ready       <= 1'b0;
      unlock_seen <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      ready    <= (state_next == RUN);
      if (!lk && (state == HOLDOFF || state == RUN)) unlock_seen <= 1'b1;
      else if (unlock_clr)                           unlock_seen <= 1'b0;
    end
  end

  // Accumulators stop on the leaving edge so cen is already 0 when ready drops.
  assign acc_run = (state == RUN) && (state_next == RUN);

  always_ff @(posedge refclk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst)           inc_reg[k] <= DEFAULT_INC[k*IW +: IW];
      else if (inc_load) inc_reg[k] <= IW'(sat_inc(32'(inc_in[k*IW +: IW]), ACC_W));
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pll_cen_acc #(.ACC_W(ACC_W)) u_acc (
      .refclk (refclk),
      .rst    (rst),
      .run    (acc_run),
      .clr    (inc_load),
      .inc    (inc_reg[k]),
      .cen    (cen[k])
    );
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed bench for pll_cen_gen: lock start-up, fractional rates, boundaries,
// lock loss, realignment on load, HOLDOFF glitch and reset mid-operation.
module tb_pll_cen_gen;

  localparam int NUM_CH      = 2;
  localparam int ACC_W       = 16;
  localparam int HOLD_CYCLES = 8;
  localparam int IW          = ACC_W + 1;
  // ch0 = 0x8000 (every 2nd cycle), ch1 = 0x4000 (every 4th cycle)
  localparam logic [NUM_CH*IW-1:0] TB_DEFAULT = {17'h04000, 17'h08000};

  logic                   refclk = 1'b0;
  logic                   rst;
  logic                   pll_locked;
  logic                   inc_load;
  logic [NUM_CH*IW-1:0]   inc_in;
  logic                   unlock_clr;
  logic [NUM_CH-1:0]      cen;
  logic                   ready;
  logic                   unlock_seen;

  int checks   = 0;
  int failures = 0;
  logic [1:0] obs [1:64];

  always #5 refclk = ~refclk;

  pll_cen_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .HOLD_CYCLES(HOLD_CYCLES), .DEFAULT_INC(TB_DEFAULT)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .inc_load(inc_load),
    .inc_in(inc_in), .unlock_clr(unlock_clr), .cen(cen), .ready(ready),
    .unlock_seen(unlock_seen)
  );

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Enable expected in RUN cycle n: floor(n*inc/2^ACC_W) steps up from n-1.
  function automatic logic carry_at(input longint inc, input int n);
    if (n <= 0) return 1'b0;
    return ((longint'(n) * inc) >> ACC_W) != ((longint'(n - 1) * inc) >> ACC_W);
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 60);
  endtask

  task automatic collect(input int cycles);
    for (int i = 1; i <= cycles; i++) begin
      tick();
      obs[i] = cen;
    end
  endtask

  task automatic load_inc(input logic [NUM_CH*IW-1:0] value);
    inc_in   = value;
    inc_load = 1'b1;
    tick();
    inc_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; inc_load = 1'b0; unlock_clr = 1'b0; inc_in = '0;
    repeat (4) tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (cen !== 2'b00) begin failures++; $display("[TB] FAIL reset_cen: got %b expected 00", cen); end
    checks++;
    if (unlock_seen !== 1'b0) begin failures++; $display("[TB] FAIL reset_unlock: got %b expected 0", unlock_seen); end
    rst = 1'b0;
  endtask

  task automatic test_lock_startup();
    int n, bad, c0, c1, coinc;
    pll_locked = 1'b1;
    wait_ready(n);
    // 2 synchroniser edges + 8 locked cycles (1 in WAIT_LOCK, 7 in HOLDOFF)
    checks++;
    if (n !== 10) begin failures++; $display("[TB] FAIL startup_latency: got %0d expected 10", n); end
    checks++;
    if (cen !== 2'b00) begin failures++; $display("[TB] FAIL startup_r0: got %b expected 00", cen); end
    collect(16);
    bad = 0; c0 = 0; c1 = 0; coinc = 0;
    for (int i = 1; i <= 16; i++) begin
      if (obs[i] !== {carry_at(64'h4000, i), carry_at(64'h8000, i)}) bad++;
      if (obs[i][0] === 1'b1) c0++;
      if (obs[i][1] === 1'b1) c1++;
      if (obs[i][1] === 1'b1 && obs[i][0] !== 1'b1) coinc++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL startup_pattern: got %0d wrong cycles expected 0", bad); end
    checks++;
    if (c0 !== 8 || c1 !== 4) begin failures++; $display("[TB] FAIL startup_counts: got %0d/%0d expected 8/4", c0, c1); end
    checks++;
    if (coinc !== 0) begin failures++; $display("[TB] FAIL startup_coincide: got %0d lone ch1 pulses expected 0", coinc); end
  endtask

  task automatic test_fractional();
    int p0, p1, last, badspace, badpos;
    load_inc({17'h04000, 17'h05555});
    checks++;
    if (cen !== 2'b00 || ready !== 1'b1) begin
      failures++; $display("[TB] FAIL frac_realign: got cen=%b ready=%b expected 00/1", cen, ready);
    end
    p0 = 0; p1 = 0; last = 0; badspace = 0; badpos = 0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      if (cen[0] === 1'b1) begin
        p0++;
        if (n - last < 3 || n - last > 4) badspace++;
        last = n;
      end
      if (cen[1] === 1'b1) p1++;
      if (cen !== {carry_at(64'h4000, n), carry_at(64'h5555, n)}) badpos++;
    end
    checks++;
    if (p0 !== 999) begin failures++; $display("[TB] FAIL frac_count0: got %0d expected 999", p0); end
    checks++;
    if (p1 !== 750) begin failures++; $display("[TB] FAIL frac_count1: got %0d expected 750", p1); end
    checks++;
    if (badspace !== 0) begin failures++; $display("[TB] FAIL frac_spacing: got %0d bad gaps expected 0", badspace); end
    checks++;
    if (badpos !== 0) begin failures++; $display("[TB] FAIL frac_positions: got %0d wrong cycles expected 0", badpos); end
  endtask

  task automatic test_boundary();
    int bad;
    load_inc({17'h1FFFF, 17'h00000});
    checks++;
    if (cen !== 2'b00) begin failures++; $display("[TB] FAIL bound_r0: got %b expected 00", cen); end
    collect(20);
    bad = 0;
    for (int i = 1; i <= 20; i++) if (obs[i] !== 2'b10) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL bound_pattern: got %0d wrong cycles expected 0", bad); end
  endtask

  task automatic test_lock_loss();
    int n, bad;
    pll_locked = 1'b0;
    tick(); tick();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL loss_sync_latency: got ready=%b expected 1", ready); end
    // lk is low now while still in RUN; a load here must still update the increments
    load_inc({17'h10000, 17'h05555});
    checks++;
    if (ready !== 1'b0 || cen !== 2'b00) begin
      failures++; $display("[TB] FAIL loss_outputs: got ready=%b cen=%b expected 0/00", ready, cen);
    end
    checks++;
    if (unlock_seen !== 1'b1) begin failures++; $display("[TB] FAIL loss_unlock: got %b expected 1", unlock_seen); end
    pll_locked = 1'b1;
    wait_ready(n);
    checks++;
    if (n !== 10) begin failures++; $display("[TB] FAIL relock_latency: got %0d expected 10", n); end
    checks++;
    if (cen !== 2'b00) begin failures++; $display("[TB] FAIL relock_r0: got %b expected 00", cen); end
    collect(12);
    bad = 0;
    for (int i = 1; i <= 12; i++) if (obs[i] !== {1'b1, carry_at(64'h5555, i)}) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL relock_pattern: got %0d wrong cycles expected 0", bad); end
    unlock_clr = 1'b1;
    tick();
    unlock_clr = 1'b0;
    checks++;
    if (unlock_seen !== 1'b0) begin failures++; $display("[TB] FAIL unlock_clr: got %b expected 0", unlock_seen); end
  endtask

  task automatic test_load_in_run();
    int n, bad;
    repeat (5) tick();
    load_inc({17'h04000, 17'h08000});
    checks++;
    if (cen !== 2'b00 || ready !== 1'b1) begin
      failures++; $display("[TB] FAIL load_realign: got cen=%b ready=%b expected 00/1", cen, ready);
    end
    collect(8);
    bad = 0;
    for (int i = 1; i <= 8; i++) if (obs[i] !== {carry_at(64'h4000, i), carry_at(64'h8000, i)}) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL load_pattern: got %0d wrong cycles expected 0", bad); end
    // Drop lock, clear the flag, then relock with a one-cycle lk glitch in HOLDOFF
    pll_locked = 1'b0;
    repeat (3) tick();
    unlock_clr = 1'b1;
    tick();
    unlock_clr = 1'b0;
    checks++;
    if (unlock_seen !== 1'b0) begin failures++; $display("[TB] FAIL glitch_preclear: got %b expected 0", unlock_seen); end
    pll_locked = 1'b1;
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    unlock_clr = 1'b1;
    tick();
    unlock_clr = 1'b0;
    n = 7;
    checks++;
    if (unlock_seen !== 1'b1) begin failures++; $display("[TB] FAIL glitch_set_wins: got %b expected 1", unlock_seen); end
    do begin
      tick();
      n++;
    end while (!ready && n < 60);
    checks++;
    if (n !== 15) begin failures++; $display("[TB] FAIL glitch_relock: got %0d expected 15", n); end
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    load_inc({17'h10000, 17'h05555});
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (cen !== 2'b00 || ready !== 1'b0 || unlock_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_outputs: got cen=%b ready=%b unlock=%b expected 00/0/0", cen, ready, unlock_seen);
    end
    rst = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 10) begin failures++; $display("[TB] FAIL rst_relock: got %0d expected 10", n); end
    collect(8);
    bad = 0;
    for (int i = 1; i <= 8; i++) if (obs[i] !== {carry_at(64'h4000, i), carry_at(64'h8000, i)}) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL rst_default_inc: got %0d wrong cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_lock_startup();
    test_fractional();
    test_boundary();
    test_lock_loss();
    test_load_in_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
